// File: rtl/riscv_pkg.sv
// riscv_pkg: writeback-select, load funct3 and opcode encodings plus the writeback FSM state type
package riscv_pkg;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN} wb_state_e;
  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3 == F3_LH || f3 == F3_LHU) && a[0]) || (f3 == F3_LW && a != 2'b00);
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword of a load word and sign- or zero-extends it
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = lane == 2'd0 ? rdata[7:0] : lane == 2'd1 ? rdata[15:8] : lane == 2'd2 ? rdata[23:16] : rdata[31:24];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
           funct3 == F3_LBU ? {24'd0, b} :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LHU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage committing ALU/PC4 results and aligned load data, with load wait, flush drain and misaligned detection
module wb_stage
  import riscv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic [1:0]  i_wb_sel,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_flush,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_wb_reg_write,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned
);
  wb_state_e   state_q, state_d;
  logic        ld_we_q, ld_we_d, pend_q, pend_d, we_q, we_d, mis_q, mis_d;
  logic [4:0]  ld_rd_q, ld_rd_d, pend_rd_q, pend_rd_d, rd_q, rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic [31:0] pend_data_q, pend_data_d, data_q, data_d, ld_data, nl_data;
  logic        accept, new_we;
  load_align u_align (.funct3(ld_f3_q), .lane(ld_lane_q), .rdata(i_dmem_rdata), .data(ld_data));
  always_comb begin
    state_d = state_q;
    ld_we_d = ld_we_q;
    ld_rd_d = ld_rd_q;
    ld_f3_d = ld_f3_q;
    ld_lane_d = ld_lane_q;
    pend_d = pend_q;
    pend_rd_d = pend_rd_q;
    pend_data_d = pend_data_q;
    we_d = 1'b0;
    rd_d = rd_q;
    data_d = data_q;
    mis_d = 1'b0;
    o_stall = state_q == IDLE ? pend_q : !i_dmem_rvalid;
    accept = i_valid && !o_stall && !i_flush;
    new_we = i_reg_write && i_rd != 5'd0;
    nl_data = i_wb_sel == WB_PC4 ? i_pc_plus4 : i_alu_result;
    if (state_q == IDLE && pend_q) begin
      pend_d = 1'b0;
      if (!i_flush) begin
        we_d = 1'b1;
        rd_d = pend_rd_q;
        data_d = pend_data_q;
      end
    end
    if (state_q != IDLE) begin
      if (i_dmem_rvalid) begin
        state_d = IDLE;
        if (state_q == WAIT_LOAD && !i_flush && ld_we_q) begin
          we_d = 1'b1;
          rd_d = ld_rd_q;
          data_d = ld_data;
        end
      end else if (i_flush) begin
        state_d = DRAIN;
      end
    end
    if (accept) begin
      if (i_wb_sel != WB_MEM) begin
        if (new_we && we_d) begin
          pend_d = 1'b1;
          pend_rd_d = i_rd;
          pend_data_d = nl_data;
        end else if (new_we) begin
          we_d = 1'b1;
          rd_d = i_rd;
          data_d = nl_data;
        end
      end else if (load_misaligned(i_funct3, i_alu_result[1:0])) begin
        mis_d = 1'b1;
      end else begin
        state_d = WAIT_LOAD;
        ld_we_d = new_we;
        ld_rd_d = i_rd;
        ld_f3_d = i_funct3;
        ld_lane_d = i_alu_result[1:0];
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ld_we_q <= 1'b0;
      ld_rd_q <= '0;
      ld_f3_q <= '0;
      ld_lane_q <= '0;
      pend_q <= 1'b0;
      pend_rd_q <= '0;
      pend_data_q <= '0;
      we_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_we_q <= ld_we_d;
      ld_rd_q <= ld_rd_d;
      ld_f3_q <= ld_f3_d;
      ld_lane_q <= ld_lane_d;
      pend_q <= pend_d;
      pend_rd_q <= pend_rd_d;
      pend_data_q <= pend_data_d;
      we_q <= we_d;
      rd_q <= rd_d;
      data_q <= data_d;
      mis_q <= mis_d;
    end
  end
  assign o_wb_reg_write = we_q;
  assign o_wb_rd = rd_q;
  assign o_wb_data = data_q;
  assign o_misaligned = mis_q;
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have: i_clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: i_rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: i_valid  input  1  MEM-stage instruction present.
REQ-004 SHALL have: i_reg_write  input  1  instruction writes rd.
REQ-005 SHALL have: i_rd  input  5  destination register.
REQ-006 SHALL have: i_wb_sel  input  2  writeback source: ALU=00, MEM=01, PC4=10; 11 is treated as ALU.
REQ-007 SHALL have: i_funct3  input  3  load width/sign (LB, LH, LW, LBU, LHU).
REQ-008 SHALL have: i_alu_result  input  32  ALU result / load address.
REQ-009 SHALL have: i_pc_plus4  input  32  link value.
REQ-010 SHALL have: i_flush  input  1  discard the instruction not yet committed.
REQ-011 SHALL have: i_dmem_rvalid  input  1  load data valid.
REQ-012 SHALL have: i_dmem_rdata  input  32  raw load word.
REQ-013 SHALL have: o_stall  output  1  upstream hold request.
REQ-014 SHALL have: o_wb_reg_write  output  1  register-file write enable (feeds forwarding).
REQ-015 SHALL have: o_wb_rd  output  5  write address.
REQ-016 SHALL have: o_wb_data  output  32  write data.
REQ-017 SHALL have: o_misaligned  output  1  one-cycle misaligned-load pulse.

Function
REQ-018 SHALL accept the input bundle on a rising edge when i_valid=1, o_stall=0 and i_flush=0; otherwise it captures nothing.
REQ-019 SHALL register o_wb_reg_write, o_wb_rd, o_wb_data and o_misaligned; o_stall is combinational.
REQ-020 SHALL use FSM states IDLE, WAIT_LOAD, DRAIN.
REQ-021 IDLE: an accepted non-load (wb_sel!=MEM) commits on the next cycle, with o_wb_reg_write=i_reg_write and rd!=0 and o_wb_data=ALU or PC4; latency is 1.
REQ-022 IDLE: an accepted aligned load moves to WAIT_LOAD and latches rd, funct3 and addr[1:0].
REQ-023 SHALL treat a load as misaligned when it is LH/LHU with addr[0]=1 or LW with addr[1:0]!=0; a misaligned load pulses o_misaligned next cycle, performs no write and stays in IDLE.
REQ-024 WAIT_LOAD: o_stall = !i_dmem_rvalid; when rvalid=1, the aligned data commits next cycle, FSM returns to IDLE, and a new instruction is accepted in that same edge.
REQ-025 SHALL align loads as follows: LB/LH sign-extend the selected byte/halfword; LBU/LHU zero-extend; LW passes the word; byte lane = addr[1:0], halfword lane = addr[1].
REQ-026 SHALL never assert o_wb_reg_write with o_wb_rd=0, so that consumers need no x0 check.
REQ-027 SHALL pulse o_wb_reg_write high for exactly one cycle per committed instruction.
REQ-028 i_flush in IDLE: the input is not captured. i_flush in WAIT_LOAD without rvalid: go to DRAIN. i_flush in WAIT_LOAD with rvalid: discard the data, no commit, go to IDLE.
REQ-029 DRAIN: o_stall=1 until i_dmem_rvalid; the response is discarded, then the FSM goes to IDLE.
REQ-030 SHALL ignore i_dmem_rvalid in IDLE.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately force: state=IDLE, o_wb_reg_write=0, o_wb_rd=0, o_wb_data=0, o_misaligned=0; o_stall then reads 0.
REQ-032 Reset asserted mid-WAIT_LOAD SHALL abandon the load with no commit; a later stray rvalid is ignored.

Structure
REQ-033 The shared package riscv_pkg SHALL hold: the wb_sel encoding, the load funct3 constants, the opcode constants and the FSM state enum.
REQ-034 Byte/halfword extraction and extension SHALL live in one combinational sub-module, load_align.

Verification
REQ-035 ALU op: rd=5, result 0x1234 -> next cycle write=1, rd=5, data=0x00001234, stall=0.
REQ-036 LB, addr=0x103, rdata=0x80FF_FF7F, rvalid after 3 cycles -> stall=1 for 3 cycles; then data=0xFFFFFF80 one cycle after rvalid.
REQ-037 LHU, addr=0x102, rdata=0xBEEF0000 -> data=0x0000BEEF. LW, addr=0x101 -> o_misaligned=1, write=0, no stall.
REQ-038 rd=0 with i_reg_write=1 -> o_wb_reg_write stays 0.
REQ-039 Flush while in WAIT_LOAD -> DRAIN, stall held until rvalid, no write.
REQ-040 Reset pulse during WAIT_LOAD, then rvalid -> all outputs 0, no write.
